// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: word width, HI/LO unit op codes and FSM states.
package mips_pkg;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction
endpackage

// File: rtl/mips_negate_cond.sv
// Conditional two's-complement negate: abs() on operand entry, sign fix-up on results.
module mips_negate_cond #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);
    assign res = neg ? (W'(0) - val) : val;
endmodule

// File: rtl/mips_muldiv.sv
// Iterative HI/LO multiply/divide: Start accepted only while idle, result 33 cycles later with a Done pulse.
// Busy covers the whole operation; Start/HiW/LoW are ignored while it is high.
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int ITER  = WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             HiW,
    input  logic             LoW,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CW = $clog2(ITER) + 1;

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

    logic                 sa_in, sb_in;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign sa_in = op_is_signed(op_e'(Op)) & SrcA[WIDTH-1];
    assign sb_in = op_is_signed(op_e'(Op)) & SrcB[WIDTH-1];

    mips_negate_cond #(.W(WIDTH)) u_abs_a (.val(SrcA), .neg(sa_in), .res(abs_a));
    mips_negate_cond #(.W(WIDTH)) u_abs_b (.val(SrcB), .neg(sb_in), .res(abs_b));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; quotient bits shift in at the bottom.
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
    assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    mips_negate_cond #(.W(2*WIDTH)) u_fix_prod (.val(acc_q), .neg(sa_q ^ sb_q), .res(prod_fix));
    mips_negate_cond #(.W(WIDTH)) u_fix_quo (.val(acc_q[WIDTH-1:0]), .neg(sa_q ^ sb_q), .res(quo_fix));
    mips_negate_cond #(.W(WIDTH)) u_fix_rem (.val(acc_q[2*WIDTH-1:WIDTH]), .neg(sa_q), .res(rem_fix));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    op_d    = op_e'(Op);
                    sa_d    = sa_in;
                    sb_d    = sb_in;
                    b_d     = abs_b;
                    acc_d   = {{WIDTH{1'b0}}, abs_a};
                end else begin
                    if (HiW) hi_d = SrcA;
                    if (LoW) lo_d = SrcA;
                end
            end
            ST_RUN: begin
                acc_d = op_is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (!op_is_div(op_q)) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else begin
                    // A zero divisor leaves the dividend in the remainder; re-signing restores SrcA.
                    hi_d = rem_fix;
                    lo_d = (b_q == '0) ? '1 : quo_fix;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = busy_q;
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv: stimulus pushes model results, a negedge monitor pops them on Done.
module tb_mips_muldiv;
    logic        CLK = 1'b0;
    logic        RST, Start, HiW, LoW;
    logic [1:0]  Op;
    logic [31:0] SrcA, SrcB;
    logic        Busy, Done;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    mips_muldiv dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
        .HiW(HiW), .LoW(LoW), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Architectural reference: plain 64-bit arithmetic, truncating division.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: p = sa * sb;
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    always @(negedge CLK) begin
        if (!RST && Done) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=1 required=0 cyc=%0d", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("result_hi", 64'(HI), 64'(e.hi));
                chk("result_lo", 64'(LO), 64'(e.lo));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Call at a negedge with the unit idle; returns just after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] m;
        Start = 1'b1;
        Op    = op;
        SrcA  = a;
        SrcB  = b;
        @(posedge CLK);
        #1;
        m     = model(op, a, b);
        e.hi  = m[63:32];
        e.lo  = m[31:0];
        e.cyc = cyc + 33;
        exp_q.push_back(e);
        Start = 1'b0;
        HiW   = 1'b0;
        LoW   = 1'b0;
        Op    = 2'($urandom_range(3));
        SrcA  = $urandom;
        SrcB  = $urandom;
    endtask

    task automatic wait_idle(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge CLK);
            if (Busy) busy_cycles++;
            if (!Busy && exp_q.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle_timeout actual=busy required=idle");
    endtask

    logic [1:0]  d_op [7] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
    logic [31:0] d_a  [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                              32'd100, 32'h8000_0000, 32'd5};
    logic [31:0] d_b  [7] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                              32'd7, 32'hFFFF_FFFF, 32'd0};

    initial begin
        int          bc;
        bit          seen;
        logic [31:0] ra, rb;
        RST = 1'b1; Start = 1'b0; HiW = 1'b0; LoW = 1'b0;
        Op = 2'b00; SrcA = '0; SrcB = '0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        chk("reset_busy", 64'(Busy), 64'(0));
        chk("reset_done", 64'(Done), 64'(0));
        chk("reset_hi", 64'(HI), 64'(0));
        chk("reset_lo", 64'(LO), 64'(0));
        @(negedge CLK);

        for (int i = 0; i < 7; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            wait_idle(bc);
            if (i == 0) chk("busy_cycles", 64'(bc), 64'(33));
        end

        // Idle-side register writes
        HiW = 1'b1; SrcA = 32'h1234_5678;
        @(posedge CLK); #1 HiW = 1'b0;
        chk("mthi_hi", 64'(HI), 64'h1234_5678);
        chk("mthi_lo_kept", 64'(LO), 64'hFFFF_FFFF);
        @(negedge CLK);
        LoW = 1'b1; SrcA = 32'h9ABC_DEF0;
        @(posedge CLK); #1 LoW = 1'b0;
        chk("mtlo_lo", 64'(LO), 64'h9ABC_DEF0);
        @(negedge CLK);
        HiW = 1'b1; LoW = 1'b1; SrcA = 32'hCAFE_F00D;
        @(posedge CLK); #1 HiW = 1'b0; LoW = 1'b0;
        chk("mthilo_hi", 64'(HI), 64'hCAFE_F00D);
        chk("mthilo_lo", 64'(LO), 64'hCAFE_F00D);
        @(negedge CLK);

        // Writes alongside an accepted Start, and Start/writes while busy, are all dropped
        HiW = 1'b1; LoW = 1'b1;
        issue(2'b11, 32'd100, 32'd7);
        chk("start_cycle_hiw_hi", 64'(HI), 64'hCAFE_F00D);
        chk("start_cycle_low_lo", 64'(LO), 64'hCAFE_F00D);
        repeat (5) @(negedge CLK);
        Start = 1'b1; Op = 2'b01; SrcA = 32'd9; SrcB = 32'd9; HiW = 1'b1; LoW = 1'b1;
        @(posedge CLK); #1;
        Start = 1'b0; HiW = 1'b0; LoW = 1'b0;
        chk("busy_hiw_hi", 64'(HI), 64'hCAFE_F00D);
        chk("busy_low_lo", 64'(LO), 64'hCAFE_F00D);
        chk("busy_still", 64'(Busy), 64'(1));
        wait_idle(bc);
        repeat (3) @(negedge CLK);
        chk("no_restart_busy", 64'(Busy), 64'(0));

        // Start presented in the Done cycle is accepted
        issue(2'b00, 32'd1234, 32'hFFFF_FF00);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (Done) seen = 1'b1;
        end
        chk("b2b_done_seen", 64'(seen), 64'(1));
        issue(2'b11, 32'hDEAD_BEEF, 32'd1000);
        wait_idle(bc);

        // Asynchronous reset aborts a running operation
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (10) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        chk("abort_busy", 64'(Busy), 64'(0));
        chk("abort_hi", 64'(HI), 64'(0));
        chk("abort_lo", 64'(LO), 64'(0));
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        chk("abort_idle", 64'(Busy), 64'(0));
        issue(2'b01, 32'd3, 32'd4);
        wait_idle(bc);

        // Randomized operations with biased corner operands
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(15));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            issue(2'($urandom_range(3)), ra, rb);
            wait_idle(bc);
        end

        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
